mem_port_arbiter: RTL

Sequences the single shared memory port between instruction fetch and the LW/SW data path of the 16-bit core. It accepts a fetch request and a data read/write request, then grants one at a time. It drives the multi-cycle memory and returns completion pulses and captured read data. It also raises a busy/stall signal that freezes the PC and pipeline while an access is outstanding.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_timeout_cnt.sv | 38 +++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared state encoding, grant codes and defaults for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_I = 3'd1,
    WAIT_I  = 3'd2,
    ISSUE_D = 3'd3,
    WAIT_D  = 3'd4
  } arb_state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait-cycle counter: cleared on issue, counts WAIT cycles, flags the last allowed one.
module mem_timeout_cnt
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // tc marks the TIMEOUT-th WAIT cycle, so the arbiter leaves after exactly TIMEOUT waits
  assign tc_o = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory port between instruction fetch and LW/SW.
// Define ARB_FAIR_EN to let fetch win a tie when the previous grant went to data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              busy,
  output logic              err
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              wr_q, wr_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic              err_q, err_d;
  logic              d_req, pick_d, in_issue, in_wait, cnt_tc;

`ifdef ARB_FAIR_EN
  logic last_gnt_q, last_gnt_d;
`endif

  assign d_req    = d_rd | d_wr;
  assign in_issue = (state_q == ISSUE_I) || (state_q == ISSUE_D);
  assign in_wait  = (state_q == WAIT_I) || (state_q == WAIT_D);

`ifdef ARB_FAIR_EN
  assign pick_d = d_req && !(if_req && (last_gnt_q == GNT_D));
`else
  assign pick_d = d_req;
`endif

  mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk  (clk),
    .rst  (rst),
    .clr_i(in_issue),
    .en_i (in_wait),
    .tc_o (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    err_d      = err_q;
`ifdef ARB_FAIR_EN
    last_gnt_d = last_gnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_d || if_req) begin
          addr_d  = pick_d ? d_addr : if_addr;
          wdata_d = d_wdata;
          wr_d    = pick_d && d_wr;
          state_d = pick_d ? ISSUE_D : ISSUE_I;
`ifdef ARB_FAIR_EN
          last_gnt_d = pick_d ? GNT_D : GNT_I;
`endif
        end
      end
      ISSUE_I: state_d = WAIT_I;
      ISSUE_D: state_d = WAIT_D;
      WAIT_I: begin
        if (mem_valid) begin
          if_rdata_d = mem_rdata;
          if_done_d  = 1'b1;
          state_d    = IDLE;
        end else if (cnt_tc) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_D: begin
        if (mem_valid) begin
          if (!wr_q) d_rdata_d = mem_rdata;
          d_done_d = 1'b1;
          state_d  = IDLE;
        end else if (cnt_tc) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // a completion with nothing outstanding, or a read+write request, is a protocol error
    if (mem_valid && !in_wait) err_d = 1'b1;
    if (d_rd && d_wr)          err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      err_q      <= 1'b0;
`ifdef ARB_FAIR_EN
      last_gnt_q <= GNT_I;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      err_q      <= err_d;
`ifdef ARB_FAIR_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

  assign mem_en    = in_issue;
  assign mem_wr    = (state_q == ISSUE_D) && wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE) | if_req | d_req;

endmodule
